int_alu_issue: RTL and testbench

INT_ALU_ISSUE -- requirements
Module: int_alu_issue

---
 rtl/int_alu_issue_if.sv | 36 +++
 rtl/int_alu_issue.sv | 127 ++++++++++++
 tb/tb_int_alu_issue.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/int_alu_issue_if.sv
// Dispatch-to-issue and issue-to-ALU signal bundle for the integer ALU issue queue.
// The slave modport is the queue; the master modport is the dispatch/ALU side.
interface int_alu_issue_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int R_ADDR         = 6,
  parameter int ROB_INDEX_BITS = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [4:0]                in_microop;
  logic [DATA_WIDTH-1:0]     in_data1;
  logic [DATA_WIDTH-1:0]     in_data2;
  logic [R_ADDR-1:0]         in_destination;
  logic [ROB_INDEX_BITS-1:0] in_ticket;

  logic                      busy_fu;

  logic                      issue_valid;
  logic [4:0]                issue_microop;
  logic [DATA_WIDTH-1:0]     issue_data1;
  logic [DATA_WIDTH-1:0]     issue_data2;
  logic [R_ADDR-1:0]         issue_destination;
  logic [ROB_INDEX_BITS-1:0] issue_ticket;

  modport slave (
    input  in_valid, in_microop, in_data1, in_data2, in_destination, in_ticket, busy_fu,
    output in_ready, issue_valid, issue_microop, issue_data1, issue_data2,
           issue_destination, issue_ticket
  );

  modport master (
    output in_valid, in_microop, in_data1, in_data2, in_destination, in_ticket, busy_fu,
    input  in_ready, issue_valid, issue_microop, issue_data1, issue_data2,
           issue_destination, issue_ticket
  );
endinterface

// File: rtl/int_alu_issue.sv
// In-order issue queue for the integer ALU. Holds dispatched ops and releases the head
// only when its writeback slot cannot collide with an in-flight multi-cycle op.
module int_alu_issue #(
  parameter int DATA_WIDTH     = 32,
  parameter int R_ADDR         = 6,
  parameter int ROB_INDEX_BITS = 3,
  parameter int DEPTH          = 4,
  parameter int MUL_LAT        = 3,
  parameter int DIV_LAT        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  int_alu_issue_if.slave             bus,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [15:0]                stall_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]                microop;
    logic [DATA_WIDTH-1:0]     data1;
    logic [DATA_WIDTH-1:0]     data2;
    logic [R_ADDR-1:0]         destination;
    logic [ROB_INDEX_BITS-1:0] ticket;
  } op_t;

  op_t              mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DIV_LAT:0] res_q, res_d, res_shift;
  logic [15:0]      stall_q, stall_d;

  op_t  head;
  op_t  in_op;
  logic is_mul, is_div, is_single;
  logic class_ok;
  logic in_ready;
  logic accept;
  logic issue;

  // Reservation vector ages by one slot per cycle; the top slot refills with zero.
  generate
    for (genvar gi = 0; gi < DIV_LAT; gi++) begin : g_res_shift
      assign res_shift[gi] = res_q[gi+1];
    end
  endgenerate
  assign res_shift[DIV_LAT] = 1'b0;

  assign head      = mem_q[rd_ptr_q];
  assign is_mul    = head.microop inside {[5'd2:5'd5]};
  assign is_div    = head.microop inside {[5'd6:5'd9]};
  assign is_single = ~is_mul & ~is_div;
  assign class_ok  = is_single | (is_mul & ~res_q[MUL_LAT]) | (is_div & ~res_q[DIV_LAT]);

  assign in_ready = (occ_q < OCC_W'(DEPTH)) & ~rst;
  assign accept   = bus.in_valid & in_ready & ~flush;
  assign issue    = (occ_q != '0) & ~bus.busy_fu & ~flush & ~rst & ~res_q[0] & class_ok;

  assign in_op.microop     = bus.in_microop;
  assign in_op.data1       = bus.in_data1;
  assign in_op.data2       = bus.in_data2;
  assign in_op.destination = bus.in_destination;
  assign in_op.ticket      = bus.in_ticket;

  always_comb begin
    res_d = res_shift;
    if (issue && is_mul) res_d[MUL_LAT-1] = 1'b1;
    if (issue && is_div) res_d[DIV_LAT-1] = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (issue)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(accept) - OCC_W'(issue);
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((occ_q != '0) && !issue && !flush && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  // Payload storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= in_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      res_q    <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      res_q    <= res_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.issue_valid       = issue;
  assign bus.issue_microop     = head.microop;
  assign bus.issue_data1       = head.data1;
  assign bus.issue_data2       = head.data2;
  assign bus.issue_destination = head.destination;
  assign bus.issue_ticket      = head.ticket;
  assign occupancy             = occ_q;
  assign stall_count           = stall_q;

endmodule

// File: tb/tb_int_alu_issue.sv
// Randomized and directed stimulus for int_alu_issue, checked by a cycle-level scoreboard
// that tracks queued ops and absolute writeback cycles of in-flight multi-cycle ops.
module tb_int_alu_issue;

  localparam int DW      = 32;
  localparam int RA      = 6;
  localparam int RB      = 3;
  localparam int DEPTH   = 4;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  occupancy;
  logic [15:0] stall_count;

  int_alu_issue_if #(.DATA_WIDTH(DW), .R_ADDR(RA), .ROB_INDEX_BITS(RB)) bus_if ();

  int_alu_issue #(
    .DATA_WIDTH(DW), .R_ADDR(RA), .ROB_INDEX_BITS(RB),
    .DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus_if),
    .occupancy  (occupancy),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    uop;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [RA-1:0] dst;
    logic [RB-1:0] tk;
  } op_t;

  op_t    sbq[$];
  bit     wb[longint];
  longint cyc = 0;
  int     stall_m = 0;
  int     checks = 0;
  int     errors = 0;
  bit     acc_flag = 0;
  int     n_issued = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // 0 = single-cycle, 1 = multiply class, 2 = divide class
  function automatic int op_class(input logic [4:0] u);
    if (u >= 5'd2 && u <= 5'd5) return 1;
    if (u >= 5'd6 && u <= 5'd9) return 2;
    return 0;
  endfunction

  function automatic op_t mk_op(input logic [4:0] u);
    op_t o;
    o.uop = u;
    o.d1  = $urandom;
    o.d2  = $urandom;
    o.dst = RA'($urandom);
    o.tk  = RB'($urandom);
    return o;
  endfunction

  task automatic drive(input bit v, input op_t op, input bit b, input bit f, input bit r);
    @(posedge clk);
    #1;
    bus_if.in_valid       = v;
    bus_if.in_microop     = op.uop;
    bus_if.in_data1       = op.d1;
    bus_if.in_data2       = op.d2;
    bus_if.in_destination = op.dst;
    bus_if.in_ticket      = op.tk;
    bus_if.busy_fu        = b;
    flush                 = f;
    rst                   = r;
    #3;
    // sbq.size() here equals the occupancy the queue holds during this cycle
    acc_flag = v && !r && !f && (sbq.size() < DEPTH);
    if (acc_flag) sbq.push_back(op);
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) drive(1'b0, mk_op(5'd0), b, 1'b0, 1'b0);
  endtask

  // Monitor: compares every observable output each cycle, pops the scoreboard on issue.
  always @(negedge clk) begin
    int  eo;
    bit  er;
    bit  ei;
    int  c;
    op_t h;
    eo = sbq.size() - int'(acc_flag);
    er = (eo < DEPTH) && !rst;
    c  = 0;
    ei = 1'b0;
    check("occupancy", 128'(occupancy), 128'(eo));
    check("in_ready", 128'(bus_if.in_ready), 128'(er));
    check("stall_count", 128'(stall_count), 128'(stall_m));
    if (eo > 0) begin
      h  = sbq[0];
      c  = op_class(h.uop);
      ei = !rst && !bus_if.busy_fu && !flush && !wb.exists(cyc) &&
           ((c == 0) || (c == 1 && !wb.exists(cyc + MUL_LAT)) ||
            (c == 2 && !wb.exists(cyc + DIV_LAT)));
    end
    check("issue_valid", 128'(bus_if.issue_valid), 128'(ei));
    if (ei && bus_if.issue_valid)
      check("issue_fields",
            128'({bus_if.issue_microop, bus_if.issue_data1, bus_if.issue_data2,
                  bus_if.issue_destination, bus_if.issue_ticket}),
            128'({h.uop, h.d1, h.d2, h.dst, h.tk}));
    if (rst) begin
      sbq.delete();
      wb.delete();
      stall_m = 0;
    end else begin
      if (ei) begin
        void'(sbq.pop_front());
        n_issued++;
        if (c == 1) wb[cyc + MUL_LAT] = 1'b1;
        if (c == 2) wb[cyc + DIV_LAT] = 1'b1;
      end
      if (flush) sbq.delete();
      if (eo > 0 && !ei && !flush && stall_m < 65535) stall_m++;
    end
    if (wb.exists(cyc)) wb.delete(cyc);
    cyc++;
  end

  initial begin
    op_t o;
    int  tries;
    bus_if.in_valid       = 1'b0;
    bus_if.in_microop     = '0;
    bus_if.in_data1       = '0;
    bus_if.in_data2       = '0;
    bus_if.in_destination = '0;
    bus_if.in_ticket      = '0;
    bus_if.busy_fu        = 1'b0;

    for (int i = 0; i < 3; i++) drive(1'b0, mk_op(5'd0), 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // back-to-back single-cycle ops
    drive(1'b1, mk_op(5'b00000), 1'b0, 1'b0, 1'b0);
    drive(1'b1, mk_op(5'b01100), 1'b0, 1'b0, 1'b0);
    drive(1'b1, mk_op(5'b01011), 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    check("b2b_no_stall", 128'(stall_count), 128'(0));

    // multiply followed by adds colliding with its writeback slot
    drive(1'b1, mk_op(5'b00010), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, mk_op(5'b00000), 1'b0, 1'b0, 1'b0);
    idle(8, 1'b0);

    // fill to full while the ALU is busy, fifth op held off until drain
    for (int i = 0; i < 4; i++) drive(1'b1, mk_op(5'($urandom_range(10, 31))), 1'b1, 1'b0, 1'b0);
    o = mk_op(5'b00001);
    for (int i = 0; i < 3; i++) drive(1'b1, o, 1'b1, 1'b0, 1'b0);
    check("full_hold", 128'(acc_flag), 128'(0));
    tries = 0;
    do begin
      drive(1'b1, o, 1'b0, 1'b0, 1'b0);
      tries++;
    end while (!acc_flag && tries < 20);
    check("fifth_accepted", 128'(acc_flag), 128'(1));
    idle(6, 1'b0);

    // divide issues, then flush drops the rest; later singles must dodge its writeback
    drive(1'b1, mk_op(5'b00110), 1'b1, 1'b0, 1'b0);
    drive(1'b1, mk_op(5'b00000), 1'b1, 1'b0, 1'b0);
    drive(1'b1, mk_op(5'b00000), 1'b1, 1'b0, 1'b0);
    drive(1'b0, mk_op(5'b00000), 1'b0, 1'b0, 1'b0);
    drive(1'b1, mk_op(5'b00000), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, mk_op(5'b00000), 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);

    // reset mid-run with ops queued and a multiply in flight
    drive(1'b1, mk_op(5'b00011), 1'b0, 1'b0, 1'b0);
    drive(1'b1, mk_op(5'b00000), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, mk_op(5'b00111), 1'b1, 1'b0, 1'b0);
    drive(1'b0, mk_op(5'b00000), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), mk_op(5'($urandom)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 60) == 0),
            ($urandom_range(0, 250) == 0));
    end
    idle(DIV_LAT + 4, 1'b0);

    // two divides with the ALU held busy long enough to saturate the stall counter
    drive(1'b1, mk_op(5'b01000), 1'b0, 1'b0, 1'b0);
    drive(1'b1, mk_op(5'b01001), 1'b0, 1'b0, 1'b0);
    idle(65600, 1'b1);
    check("stall_saturated", 128'(stall_count), 128'(16'hFFFF));
    idle(DIV_LAT + 4, 1'b0);

    check("ops_issued_nonzero", 128'(n_issued > 20), 128'(1));
    check("queue_drained", 128'(occupancy), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
